// File: rtl/mem_access_if.sv
// Request/response and memory-side signals of the load/store sequencer.
// The slave modport is the sequencer itself; the master modport is the
// environment around it (CPU datapath on the request/response side and
// the byte-wide data memory on the mem_* side).
interface mem_access_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_size;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;

    // response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_rdata;

    // memory port
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_size,
        input  req_addr,
        input  req_wdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_size,
        output req_addr,
        output req_wdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-wide synchronous-read memory.
// Each byte or halfword request becomes one or two byte cycles; the
// memory's one-cycle read latency is absorbed by capturing read data one
// state after the address was presented. All outputs are registered.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ACC0  | low byte cycle at addr
// ACC1  | high byte cycle at addr+1 (halfword only); low load byte arrives
// CAP   | last load byte arrives from memory
// RESP  | load result presented until rsp_ready
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC0 = 3'd1,
        S_ACC1 = 3'd2,
        S_CAP  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                state_q;

    // latched request
    logic                  we_q;
    logic                  size_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*DATA_W-1:0]   wdata_q;

    // load assembly buffer
    logic [2*DATA_W-1:0]   rdata_q;

    // registered outputs
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [2*DATA_W-1:0]   rsp_rdata_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic                  mem_we_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    // address of the high byte; natural modulo wrap from all-ones to zero
    logic [ADDR_W-1:0]     addr_hi_d;
    assign addr_hi_d = addr_q + ADDR_W'(1);

    // Sequencer: state, request latch, load assembly and all outputs.
    // mem_rdata only ever lands in rdata_q; no decision depends on it, so
    // uninitialised memory contents cannot disturb control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        we_q        <= bus.req_we;
                        size_q      <= bus.req_size;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        // ACC0 outputs are set up on the accept edge so the
                        // first byte cycle happens in the very next cycle.
                        mem_addr_q  <= bus.req_addr;
                        mem_we_q    <= bus.req_we;
                        mem_wdata_q <= bus.req_wdata[DATA_W-1:0];
                        req_ready_q <= 1'b0;
                        state_q     <= S_ACC0;
                    end
                end

                S_ACC0: begin
                    if (size_q) begin
                        mem_addr_q  <= addr_hi_d;
                        mem_we_q    <= we_q;
                        mem_wdata_q <= wdata_q[2*DATA_W-1:DATA_W];
                        state_q     <= S_ACC1;
                    end else begin
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_CAP;
                        end
                    end
                end

                S_ACC1: begin
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        // read data for the ACC0 address is on the bus now
                        rdata_q[DATA_W-1:0] <= bus.mem_rdata;
                        state_q             <= S_CAP;
                    end
                end

                S_CAP: begin
                    mem_we_q <= 1'b0;
                    if (size_q) begin
                        rdata_q[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
                    end else begin
                        rdata_q[DATA_W-1:0]        <= bus.mem_rdata;
                        rdata_q[2*DATA_W-1:DATA_W] <= '0;
                    end
                    state_q <= S_RESP;
                end

                S_RESP: begin
                    // first RESP cycle loads the output register; from then
                    // on valid and data hold until the consumer takes them
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256x8
// synchronous-read memory attached to the memory port.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;

    mem_access_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_access_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;

    logic [7:0] mem [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte memory: write on mem_we, registered read of the presented address
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // count write cycles seen by the memory
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) we_cnt = we_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait for req_ready, then hold a request for one edge; returns #1 after
    // the accept edge
    task automatic issue(input logic we, input logic sz, input logic [7:0] a,
                         input logic [15:0] wd);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready_timeout: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
        end
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_valid_we: got rsp_valid=%b mem_we=%b required 0/0",
                            bus.rsp_valid, bus.mem_we);
        end
        total++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00 || bus.rsp_rdata !== 16'h0000) begin
            bad++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required 00/00/0000",
                            bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
        end
    endtask

    task automatic test_byte_store_load();
        int w0;
        w0 = we_cnt;
        issue(1'b1, 1'b0, 8'h10, 16'h00A5);
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h10 || bus.mem_wdata !== 8'hA5) begin
            bad++; $display("FAIL bstore_acc0: got we=%b addr=%h wdata=%h required 1/10/a5",
                            bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        total++;
        if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL bstore_done: got we=%b ready=%b required 0/1",
                            bus.mem_we, bus.req_ready);
        end
        total++;
        if (we_cnt - w0 != 1 || mem[8'h10] !== 8'hA5) begin
            bad++; $display("FAIL bstore_pulse: got pulses=%0d mem=%h required 1/a5",
                            we_cnt - w0, mem[8'h10]);
        end
        issue(1'b0, 1'b0, 8'h10, 16'h0000);
        step();
        step();
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bload_early: rsp_valid=%b at +2 required 0", bus.rsp_valid);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h00A5) begin
            bad++; $display("FAIL bload_rsp: got valid=%b rdata=%h required 1/00a5",
                            bus.rsp_valid, bus.rsp_rdata);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL bload_hs: got valid=%b ready=%b required 0/1",
                            bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_halfword();
        issue(1'b1, 1'b1, 8'h40, 16'hBEEF);
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h40 || bus.mem_wdata !== 8'hEF) begin
            bad++; $display("FAIL hstore_lo: got we=%b addr=%h wdata=%h required 1/40/ef",
                            bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h41 || bus.mem_wdata !== 8'hBE) begin
            bad++; $display("FAIL hstore_hi: got we=%b addr=%h wdata=%h required 1/41/be",
                            bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        total++;
        if (mem[8'h40] !== 8'hEF || mem[8'h41] !== 8'hBE || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL hstore_mem: got %h %h we=%b required ef be 0",
                            mem[8'h40], mem[8'h41], bus.mem_we);
        end
        issue(1'b0, 1'b1, 8'h40, 16'h0000);
        step(); step(); step();
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL hload_early: rsp_valid=%b at +3 required 0", bus.rsp_valid);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL hload_rsp: got valid=%b rdata=%h required 1/beef",
                            bus.rsp_valid, bus.rsp_rdata);
        end
        step();
        issue(1'b0, 1'b0, 8'h41, 16'h0000);
        step(); step(); step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h00BE) begin
            bad++; $display("FAIL bload_hi_byte: got valid=%b rdata=%h required 1/00be",
                            bus.rsp_valid, bus.rsp_rdata);
        end
        step();
    endtask

    task automatic test_wrap();
        issue(1'b1, 1'b1, 8'hFF, 16'h1234);
        step();
        total++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h12) begin
            bad++; $display("FAIL wrap_addr: got addr=%h wdata=%h required 00/12",
                            bus.mem_addr, bus.mem_wdata);
        end
        step();
        total++;
        if (mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12) begin
            bad++; $display("FAIL wrap_mem: got ff=%h 00=%h required 34/12",
                            mem[8'hFF], mem[8'h00]);
        end
        issue(1'b0, 1'b1, 8'hFF, 16'h0000);
        step(); step(); step(); step();
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h1234) begin
            bad++; $display("FAIL wrap_load: got valid=%b rdata=%h required 1/1234",
                            bus.rsp_valid, bus.rsp_rdata);
        end
        step();
    endtask

    task automatic test_backpressure();
        int w0;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 1'b1, 8'h40, 16'h0000);
        step(); step(); step(); step();
        w0 = we_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 1'b1;
        bus.req_addr  = 8'h40;
        bus.req_wdata = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF || bus.req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d: got valid=%b rdata=%h ready=%b required 1/beef/0",
                                c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
            step();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: got valid=%b ready=%b required 0/1",
                            bus.rsp_valid, bus.req_ready);
        end
        total++;
        if (we_cnt != w0 || mem[8'h40] !== 8'hEF || mem[8'h41] !== 8'hBE) begin
            bad++; $display("FAIL bp_ignored_req: got writes=%0d mem=%h%h required 0 beef",
                            we_cnt - w0, mem[8'h41], mem[8'h40]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        int acc_cyc [4];
        int k, cyc, w0, n;
        logic rdy;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        k = 0; cyc = 0;
        w0 = we_cnt;
        while (k < 4 && cyc < 40) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = 1'b0;
            bus.req_addr  = 8'(k);
            bus.req_wdata = {8'h00, vals[k]};
            rdy = bus.req_ready;
            step();
            if (rdy === 1'b1) begin
                acc_cyc[k] = cyc;
                k++;
            end
            cyc++;
        end
        bus.req_valid = 1'b0;
        step();
        total++;
        if (k != 4) begin
            bad++; $display("FAIL b2b_timeout: accepted %0d required 4", k);
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
                    bad++; $display("FAIL b2b_spacing_%0d: got %0d cycles required 2",
                                    i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        total++;
        if (we_cnt - w0 != 4) begin
            bad++; $display("FAIL b2b_pulses: got %0d required 4", we_cnt - w0);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, 8'(i), 16'h0000);
            n = 0;
            while (bus.rsp_valid !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== {8'h00, vals[i]}) begin
                bad++; $display("FAIL b2b_readback_%0d: got valid=%b rdata=%h required 1/%h",
                                i, bus.rsp_valid, bus.rsp_rdata, {8'h00, vals[i]});
            end
            step();
        end
    endtask

    task automatic test_reset_mid_store();
        issue(1'b1, 1'b0, 8'h21, 16'h0077);
        step();
        issue(1'b1, 1'b1, 8'h20, 16'hCAFE);
        step();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h21) begin
            bad++; $display("FAIL rst_pre_acc1: got we=%b addr=%h required 1/21",
                            bus.mem_we, bus.mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL rst_we_drop: got %b required 0", bus.mem_we);
        end
        step();
        rst_n = 1'b1;
        total++;
        if (mem[8'h20] !== 8'hFE || mem[8'h21] !== 8'h77) begin
            bad++; $display("FAIL rst_mem: got 20=%h 21=%h required fe/77",
                            mem[8'h20], mem[8'h21]);
        end
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_addr !== 8'h00 ||
            bus.mem_wdata !== 8'h00 || bus.rsp_rdata !== 16'h0000) begin
            bad++; $display("FAIL rst_outputs: got ready=%b valid=%b addr=%h wdata=%h rdata=%h required 1/0/00/00/0000",
                            bus.req_ready, bus.rsp_valid, bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
        end
        step();
        total++;
        if (bus.mem_we !== 1'b0 || mem[8'h21] !== 8'h77) begin
            bad++; $display("FAIL rst_after: got we=%b 21=%h required 0/77",
                            bus.mem_we, mem[8'h21]);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        bus.rsp_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_byte_store_load();
        test_halfword();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 8-bit synchronous-read data memory.
- Accepts byte or halfword load/store requests from the CPU datapath over a valid/ready handshake.
- Splits each request into byte-wide memory cycles and absorbs the memory's one-cycle read latency.
- Returns assembled load data over a valid/ready response channel.

Parameters:
ADDR_W, 8, byte-address width; must match the memory address width.
DATA_W, 8, memory word width; the request/response data width is 2*DATA_W.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_we  input  1  1=store, 0=load.
req_size  input  1  0=byte, 1=halfword (little-endian, two consecutive bytes).
req_addr  input  ADDR_W  byte address of the low byte.
req_wdata  input  2*DATA_W  store data; [7:0] used for byte stores.
rsp_valid  output  1  load result present.
rsp_ready  input  1  consumer accepts the result.
rsp_rdata  output  2*DATA_W  load result; byte loads zero-extended.
mem_addr  output  ADDR_W  to memory address.
mem_we  output  1  to memory write enable.
mem_wdata  output  DATA_W  to memory write data.
mem_rdata  input  DATA_W  from memory read data; valid the cycle after a read address is presented with mem_we=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: state=IDLE; all request/result registers, rsp_rdata, mem_addr and mem_wdata = 0; mem_we=0; rsp_valid=0; req_ready=1 after reset release.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/size/addr/wdata and go to ACC0.
  - ACC0: mem_addr=addr, mem_we=we, mem_wdata=wdata[7:0]. Next state: halfword -> ACC1; byte store -> IDLE; byte load -> CAP.
  - ACC1: mem_addr=(addr+1) mod 2^ADDR_W, i.e. 0xFF wraps to 0x00. mem_we=we, mem_wdata=wdata[15:8]. For a load, capture mem_rdata into rdata[7:0] this cycle. Next state: store -> IDLE; load -> CAP.
  - CAP: mem_we=0. Capture mem_rdata into rdata[7:0] (byte load) or rdata[15:8] (halfword load). Byte loads clear rdata[15:8]. Next state: RESP.
  - RESP: rsp_valid=1, rsp_rdata=rdata held stable. On rsp_ready, go to IDLE. rsp_valid and rsp_rdata stay stable while rsp_ready is low.
- mem_we is 1 only in ACC0/ACC1 for stores; it is 0 in every other state. mem_addr and mem_wdata hold their last value outside ACC states.
- Stores produce no response.
- Latency, counted from the accept edge:
  - Byte store: write at edge +1; req_ready=1 again in the cycle after that.
  - Halfword store: writes at edges +1 and +2.
  - Byte load: rsp_valid in cycle 3, after edge +3.
  - Halfword load: rsp_valid after edge +4.
- No request is accepted outside IDLE; req_valid there is ignored with no side effects. No new request is accepted in the same cycle a response handshakes; acceptance happens in the following IDLE cycle.
- Reset mid-operation: asserting rst_n=0 returns to IDLE immediately and drops mem_we combinationally, so no write occurs at the next edge. A halfword store interrupted after ACC0 leaves the low byte written and the high byte unwritten. A pending response is discarded.
- X-safety: memory contents are uninitialised. The unit must not gate control on mem_rdata; X may only propagate into rsp_rdata.

Test Plan:
- Byte store then byte load: store 0xA5 to 0x10, then load 0x10 -> mem_we pulses for exactly 1 cycle with mem_addr=0x10; rsp_rdata=0x00A5 with rsp_valid 3 cycles after the load accept.
- Halfword round trip: store 0xBEEF to 0x40 -> memory bytes 0x40=0xEF, 0x41=0xBE. Halfword load 0x40 -> rsp_rdata=0xBEEF 4 cycles after accept. Byte load 0x41 -> 0x00BE.
- Address wrap: halfword store 0x1234 to 0xFF -> 0xFF=0x34, 0x00=0x12. Halfword load 0xFF -> 0x1234.
- Response backpressure: rsp_ready held low for 5 cycles during a load -> rsp_valid and rsp_rdata stable; req_ready=0 throughout and a concurrent req_valid is ignored. Raising rsp_ready -> one handshake, then IDLE with req_ready=1.
- Back-to-back stores: req_valid held high with 4 byte stores to 0x00..0x03 -> one accept every 2 cycles; 4 single-cycle mem_we pulses; readback matches the stored values.
- Reset mid-store: rst_n asserted during ACC1 of a halfword store to 0x20 (data 0xCAFE) -> mem_we=0 immediately; 0x21 retains its prior value, 0x20=0xFE. All outputs return to reset values and req_ready=1 after release.
